// File: rtl/regfile_fwd_pkg.sv
// Shared constants and types for the register file with operand forwarding.
// Build option: REGFILE_BYPASS_EN enables EX/MEM forwarding.
package regfile_fwd_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  // Where a read port takes its operand from.
  typedef enum logic [2:0] {
    SelZero,
    SelEx,
    SelMem,
    SelWb,
    SelArray
  } src_sel_e;

endpackage

// File: rtl/regfile_fwd_fwd_mux.sv
// One read port: producer priority select plus its hazard term.
// Build option: REGFILE_BYPASS_EN selects EX/MEM forwarding vs. stall-on-any-pending.
module regfile_fwd_fwd_mux
  import regfile_fwd_pkg::*;
#(
  parameter int unsigned DataW = RegBus,
  parameter int unsigned AddrW = RegAddrBus
) (
  input  logic             rst_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  input  logic             ex_wreg_i,
  input  logic [AddrW-1:0] ex_wd_i,
  input  logic [DataW-1:0] ex_wdata_i,
  input  logic             ex_is_load_i,
  input  logic             mem_wreg_i,
  input  logic [AddrW-1:0] mem_wd_i,
  input  logic [DataW-1:0] mem_wdata_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [DataW-1:0] array_data_i,
  output logic [DataW-1:0] rdata_o,
  output logic             stall_o
);

  src_sel_e sel;
  logic     rd_live;
  logic     ex_hit;
  logic     mem_hit;
  logic     wb_hit;

  assign rd_live = (rst_i != RstEnable) && (re_i == ReadEnable) &&
                   (raddr_i != AddrW'(NOPRegAddr));
  // ex_wreg is already gated on overflow, so a dropped result never matches.
  assign ex_hit  = ex_wreg_i && (ex_wd_i == raddr_i);
  assign mem_hit = mem_wreg_i && (mem_wd_i == raddr_i);
  assign wb_hit  = (we_i == WriteEnable) && (waddr_i == raddr_i);

  always_comb begin
    sel = SelZero;
    if (rd_live) begin
`ifdef REGFILE_BYPASS_EN
      if (ex_hit) begin
        sel = SelEx;
      end else if (mem_hit) begin
        sel = SelMem;
      end else if (wb_hit) begin
        sel = SelWb;
      end else begin
        sel = SelArray;
      end
`else
      if (wb_hit) begin
        sel = SelWb;
      end else begin
        sel = SelArray;
      end
`endif
    end
  end

  always_comb begin
    rdata_o = '0;
    case (sel)
      SelEx:    rdata_o = ex_wdata_i;
      SelMem:   rdata_o = mem_wdata_i;
      SelWb:    rdata_o = wdata_i;
      SelArray: rdata_o = array_data_i;
      default:  rdata_o = '0;
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  assign stall_o = rd_live && ex_hit && ex_is_load_i;
`else
  // Without bypass any in-flight producer of the operand must drain first.
  assign stall_o = rd_live && (ex_hit || mem_hit);
  logic unused_is_load;
  assign unused_is_load = ex_is_load_i;
`endif

endmodule

// File: rtl/regfile_fwd.sv
// MIPS register file with EX/MEM/WB operand forwarding and load-use stall.
// Build option: REGFILE_BYPASS_EN (undefined: WB write-through only, stall on pending).
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int unsigned DATA_W   = RegBus,
  parameter int unsigned ADDR_W   = RegAddrBus,
  parameter int unsigned NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ex_wreg,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_wreg,
  input  logic [ADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall_req
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              stall1;
  logic              stall2;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if ((we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr))) begin
      regs_q[waddr] <= wdata;
    end
  end

  regfile_fwd_fwd_mux #(
    .DataW(DATA_W),
    .AddrW(ADDR_W)
  ) u_fwd_mux1 (
    .rst_i       (rst),
    .re_i        (re1),
    .raddr_i     (raddr1),
    .ex_wreg_i   (ex_wreg),
    .ex_wd_i     (ex_wd),
    .ex_wdata_i  (ex_wdata),
    .ex_is_load_i(ex_is_load),
    .mem_wreg_i  (mem_wreg),
    .mem_wd_i    (mem_wd),
    .mem_wdata_i (mem_wdata),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .array_data_i(regs_q[raddr1]),
    .rdata_o     (rdata1),
    .stall_o     (stall1)
  );

  regfile_fwd_fwd_mux #(
    .DataW(DATA_W),
    .AddrW(ADDR_W)
  ) u_fwd_mux2 (
    .rst_i       (rst),
    .re_i        (re2),
    .raddr_i     (raddr2),
    .ex_wreg_i   (ex_wreg),
    .ex_wd_i     (ex_wd),
    .ex_wdata_i  (ex_wdata),
    .ex_is_load_i(ex_is_load),
    .mem_wreg_i  (mem_wreg),
    .mem_wd_i    (mem_wd),
    .mem_wdata_i (mem_wdata),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .array_data_i(regs_q[raddr2]),
    .rdata_o     (rdata2),
    .stall_o     (stall2)
  );

  assign stall_req = stall1 | stall2;

endmodule
